// File: rtl/dm_stage.sv
// Data-memory stage of the MIPS pipeline: EX/DM register, word data memory, DM/WB register.
// Optional misaligned-access trap enabled by defining DM_ALIGN_CHECK_EN.
module dm_stage #(
  parameter int unsigned DM_DEPTH = 256,
  parameter int unsigned DM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_reg_wr,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_mem_to_reg,
  input  logic        ex_valid,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] ex_dm_alu_out,
  output logic [4:0]  ex_dm_rd_addr,
  output logic        ex_dm_reg_wr,
  output logic [31:0] dm_wb_mux_out,
  output logic [4:0]  dm_wb_rd_addr,
  output logic        dm_wb_reg_wr,
  output logic        dm_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  // EX/DM pipeline register
  logic            r_ex_valid;
  logic            r_ex_reg_wr;
  logic            r_ex_mem_rd;
  logic            r_ex_mem_wr;
  logic            r_ex_mem_to_reg;
  logic [XLEN-1:0] r_ex_alu;
  logic [XLEN-1:0] r_ex_rt;
  logic [RW-1:0]   r_ex_rd;

  // DM/WB pipeline register
  logic            r_wb_valid;
  logic            r_wb_reg_wr;
  logic            r_wb_mem_to_reg;
  logic            r_wb_err;
  logic [XLEN-1:0] r_wb_alu;
  logic [XLEN-1:0] r_wb_ld;
  logic [RW-1:0]   r_wb_rd;

  logic [XLEN-1:0] r_mem [DM_DEPTH];

  logic [DM_AW-1:0] w_addr;
  logic [XLEN-1:0]  w_rd_data;
  logic [XLEN-1:0]  w_ld_data;
  logic             w_misalign;
  logic             w_wr_en;

  assign w_addr    = r_ex_alu[DM_AW+1:2];
  assign w_rd_data = r_mem[w_addr];

`ifdef DM_ALIGN_CHECK_EN
  assign w_misalign = r_ex_valid & (r_ex_mem_rd | r_ex_mem_wr) & (|r_ex_alu[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_wr_en   = r_ex_valid & r_ex_mem_wr & ~stall & ~w_misalign;
  assign w_ld_data = (r_ex_mem_rd & ~w_misalign) ? w_rd_data : '0;

  // Flush wins over stall; data fields are left as-is on a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid      <= 1'b0;
      r_ex_reg_wr     <= 1'b0;
      r_ex_mem_rd     <= 1'b0;
      r_ex_mem_wr     <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
      r_ex_alu        <= '0;
      r_ex_rt         <= '0;
      r_ex_rd         <= '0;
    end else if (flush) begin
      r_ex_valid      <= 1'b0;
      r_ex_reg_wr     <= 1'b0;
      r_ex_mem_rd     <= 1'b0;
      r_ex_mem_wr     <= 1'b0;
      r_ex_mem_to_reg <= 1'b0;
    end else if (!stall) begin
      r_ex_valid      <= ex_valid;
      r_ex_reg_wr     <= ex_reg_wr;
      r_ex_mem_rd     <= ex_mem_rd;
      r_ex_mem_wr     <= ex_mem_wr;
      r_ex_mem_to_reg <= ex_mem_to_reg;
      r_ex_alu        <= ex_alu_out;
      r_ex_rt         <= ex_rt_data;
      r_ex_rd         <= ex_rd_addr;
    end
  end

  // Word store at the edge closing the DM cycle; contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_addr] <= r_ex_rt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid      <= 1'b0;
      r_wb_reg_wr     <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_err        <= 1'b0;
      r_wb_alu        <= '0;
      r_wb_ld         <= '0;
      r_wb_rd         <= '0;
    end else if (!stall) begin
      r_wb_valid      <= r_ex_valid;
      r_wb_reg_wr     <= r_ex_reg_wr & ~w_misalign;
      r_wb_mem_to_reg <= r_ex_mem_to_reg;
      r_wb_err        <= w_misalign;
      r_wb_alu        <= r_ex_alu;
      r_wb_ld         <= w_ld_data;
      r_wb_rd         <= r_ex_rd;
    end
  end

  assign ex_dm_alu_out = r_ex_alu;
  assign ex_dm_rd_addr = r_ex_rd;
  assign ex_dm_reg_wr  = r_ex_reg_wr & r_ex_valid;
  assign dm_wb_mux_out = r_wb_mem_to_reg ? r_wb_ld : r_wb_alu;
  assign dm_wb_rd_addr = r_wb_rd;
  assign dm_wb_reg_wr  = r_wb_reg_wr & r_wb_valid;
  assign dm_err        = r_wb_err;

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: directed scenarios plus randomized traffic against an instruction-level model.
module tb_dm_stage;

  localparam int unsigned DEPTH = 256;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_alu_out, ex_rt_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_mem_to_reg, ex_valid, stall, flush;
  logic [31:0] ex_dm_alu_out, dm_wb_mux_out;
  logic [4:0]  ex_dm_rd_addr, dm_wb_rd_addr;
  logic        ex_dm_reg_wr, dm_wb_reg_wr, dm_err;

  always #5 clk = ~clk;

  dm_stage dut (
    .clk(clk), .rst(rst),
    .ex_alu_out(ex_alu_out), .ex_rt_data(ex_rt_data), .ex_rd_addr(ex_rd_addr),
    .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .ex_dm_alu_out(ex_dm_alu_out), .ex_dm_rd_addr(ex_dm_rd_addr), .ex_dm_reg_wr(ex_dm_reg_wr),
    .dm_wb_mux_out(dm_wb_mux_out), .dm_wb_rd_addr(dm_wb_rd_addr), .dm_wb_reg_wr(dm_wb_reg_wr),
    .dm_err(dm_err)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  rd;
    bit reg_wr, mem_rd, mem_wr, m2r, valid;
  } ins_t;

  typedef struct {
    bit valid, reg_wr, m2r, err;
    logic [4:0]  rd;
    logic [31:0] alu, ld;
  } wb_t;

  // Model: instruction sitting in DM, result sitting in WB, and a word-addressed memory
  ins_t        m_ex;
  wb_t         m_wb;
  logic [31:0] m_mem [DEPTH];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] pre_val(input int unsigned i);
    return 32'hA5A5_0000 ^ 32'(i);
  endfunction

  function automatic ins_t mk(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                              input bit reg_wr, input bit mem_rd, input bit mem_wr, input bit m2r);
    ins_t i;
    i.alu = alu; i.rt = rt; i.rd = rd;
    i.reg_wr = reg_wr; i.mem_rd = mem_rd; i.mem_wr = mem_wr; i.m2r = m2r; i.valid = 1'b1;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = mk(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    i.valid = 1'b0;
    return i;
  endfunction

  function automatic ins_t st(input logic [31:0] a, input logic [31:0] d);
    return mk(a, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic ins_t ld(input logic [31:0] a, input logic [4:0] rd);
    return mk(a, 32'h0, rd, 1'b1, 1'b1, 1'b0, 1'b1);
  endfunction

  function automatic ins_t alu_op(input logic [31:0] v, input logic [4:0] rd);
    return mk(v, 32'h0, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic model_reset();
    m_ex = nop();
    m_wb = '{valid: 1'b0, reg_wr: 1'b0, m2r: 1'b0, err: 1'b0, rd: 5'd0, alu: 32'h0, ld: 32'h0};
  endtask

  // One clock of the pipeline as seen at instruction level
  task automatic model_edge(input ins_t i, input bit s, input bit f);
    int unsigned a;
    bit mis;
    a   = (m_ex.alu / 4) % DEPTH;
    mis = ALIGN && m_ex.valid && (m_ex.mem_rd || m_ex.mem_wr) && (m_ex.alu % 4 != 0);
    if (!s) begin
      m_wb.valid  = m_ex.valid;
      m_wb.reg_wr = m_ex.reg_wr && !mis;
      m_wb.m2r    = m_ex.m2r;
      m_wb.rd     = m_ex.rd;
      m_wb.alu    = m_ex.alu;
      m_wb.ld     = (m_ex.mem_rd && !mis) ? m_mem[a] : 32'h0;
      m_wb.err    = mis;
      if (m_ex.valid && m_ex.mem_wr && !mis) m_mem[a] = m_ex.rt;
    end
    if (f) m_ex = nop();
    else if (!s) m_ex = i;
  endtask

  task automatic step(input ins_t i, input bit s, input bit f);
    ex_alu_out = i.alu; ex_rt_data = i.rt; ex_rd_addr = i.rd;
    ex_reg_wr = i.reg_wr; ex_mem_rd = i.mem_rd; ex_mem_wr = i.mem_wr;
    ex_mem_to_reg = i.m2r; ex_valid = i.valid; stall = s; flush = f;
    @(posedge clk);
    model_edge(i, s, f);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_inputs_idle();
    #3;
    n_vec += 7;
    if (ex_dm_alu_out !== 32'h0) begin n_err++; $display("FAIL rst_ex_alu: got %h want 0", ex_dm_alu_out); end
    if (ex_dm_rd_addr !== 5'h0)  begin n_err++; $display("FAIL rst_ex_rd: got %h want 0", ex_dm_rd_addr); end
    if (ex_dm_reg_wr !== 1'b0)   begin n_err++; $display("FAIL rst_ex_reg_wr: got %b want 0", ex_dm_reg_wr); end
    if (dm_wb_mux_out !== 32'h0) begin n_err++; $display("FAIL rst_wb_mux: got %h want 0", dm_wb_mux_out); end
    if (dm_wb_rd_addr !== 5'h0)  begin n_err++; $display("FAIL rst_wb_rd: got %h want 0", dm_wb_rd_addr); end
    if (dm_wb_reg_wr !== 1'b0)   begin n_err++; $display("FAIL rst_wb_reg_wr: got %b want 0", dm_wb_reg_wr); end
    if (dm_err !== 1'b0)         begin n_err++; $display("FAIL rst_err: got %b want 0", dm_err); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_inputs_idle();
    ex_alu_out = '0; ex_rt_data = '0; ex_rd_addr = '0; ex_reg_wr = 0; ex_mem_rd = 0;
    ex_mem_wr = 0; ex_mem_to_reg = 0; ex_valid = 0; stall = 0; flush = 0;
  endtask

  task automatic preload();
    for (int unsigned i = 0; i < DEPTH; i++) step(st(32'(i * 4), pre_val(i)), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
  endtask

  task automatic test_store_load();
    step(st(32'h10, 32'hDEADBEEF), 1'b0, 1'b0);
    step(ld(32'h10, 5'd5), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    n_vec += 3;
    if (dm_wb_mux_out !== 32'hDEADBEEF) begin n_err++; $display("FAIL sl_mux: got %h want deadbeef", dm_wb_mux_out); end
    if (dm_wb_rd_addr !== 5'd5) begin n_err++; $display("FAIL sl_rd: got %0d want 5", dm_wb_rd_addr); end
    if (dm_wb_reg_wr !== 1'b1)  begin n_err++; $display("FAIL sl_reg_wr: got %b want 1", dm_wb_reg_wr); end
  endtask

  task automatic test_forwarding();
    step(alu_op(32'h7, 5'd3), 1'b0, 1'b0);
    n_vec += 3;
    if (ex_dm_alu_out !== 32'h7) begin n_err++; $display("FAIL fwd_ex_alu: got %h want 7", ex_dm_alu_out); end
    if (ex_dm_reg_wr !== 1'b1)   begin n_err++; $display("FAIL fwd_ex_reg_wr: got %b want 1", ex_dm_reg_wr); end
    if (ex_dm_rd_addr !== 5'd3)  begin n_err++; $display("FAIL fwd_ex_rd: got %0d want 3", ex_dm_rd_addr); end
    step(nop(), 1'b0, 1'b0);
    n_vec += 3;
    if (dm_wb_mux_out !== 32'h7) begin n_err++; $display("FAIL fwd_wb_mux: got %h want 7", dm_wb_mux_out); end
    if (dm_wb_reg_wr !== 1'b1)   begin n_err++; $display("FAIL fwd_wb_reg_wr: got %b want 1", dm_wb_reg_wr); end
    if (ex_dm_reg_wr !== 1'b0)   begin n_err++; $display("FAIL fwd_bubble_reg_wr: got %b want 0", ex_dm_reg_wr); end
  endtask

  task automatic test_stall();
    step(alu_op(32'h55, 5'd7), 1'b0, 1'b0);
    step(st(32'h20, 32'h1), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(ld(32'h20, 5'd9), 1'b1, 1'b0);
      n_vec += 5;
      if (ex_dm_alu_out !== 32'h20) begin n_err++; $display("FAIL stall_ex_alu[%0d]: got %h want 20", k, ex_dm_alu_out); end
      if (ex_dm_reg_wr !== 1'b0)    begin n_err++; $display("FAIL stall_ex_reg_wr[%0d]: got %b want 0", k, ex_dm_reg_wr); end
      if (dm_wb_mux_out !== 32'h55) begin n_err++; $display("FAIL stall_wb_mux[%0d]: got %h want 55", k, dm_wb_mux_out); end
      if (dm_wb_rd_addr !== 5'd7)   begin n_err++; $display("FAIL stall_wb_rd[%0d]: got %0d want 7", k, dm_wb_rd_addr); end
      if (dm_wb_reg_wr !== 1'b1)    begin n_err++; $display("FAIL stall_wb_reg_wr[%0d]: got %b want 1", k, dm_wb_reg_wr); end
    end
    step(ld(32'h20, 5'd9), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_wb_reg_wr !== 1'b0) begin n_err++; $display("FAIL stall_store_wb: got %b want 0", dm_wb_reg_wr); end
    step(nop(), 1'b0, 1'b0);
    n_vec += 2;
    if (dm_wb_mux_out !== 32'h1) begin n_err++; $display("FAIL stall_load_data: got %h want 1", dm_wb_mux_out); end
    if (dm_wb_rd_addr !== 5'd9)  begin n_err++; $display("FAIL stall_load_rd: got %0d want 9", dm_wb_rd_addr); end
  endtask

  task automatic test_flush();
    step(st(32'h30, 32'hBAD0BAD0), 1'b0, 1'b1);
    n_vec += 1;
    if (ex_dm_reg_wr !== 1'b0) begin n_err++; $display("FAIL flush_store_reg_wr: got %b want 0", ex_dm_reg_wr); end
    step(alu_op(32'h66, 5'd1), 1'b0, 1'b1);
    n_vec += 1;
    if (ex_dm_reg_wr !== 1'b0) begin n_err++; $display("FAIL flush_alu_reg_wr: got %b want 0", ex_dm_reg_wr); end
    step(ld(32'h30, 5'd4), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_wb_mux_out !== pre_val(12)) begin n_err++; $display("FAIL flush_no_write: got %h want %h", dm_wb_mux_out, pre_val(12)); end
    // flush and stall together: EX/DM bubbles, DM/WB holds
    step(alu_op(32'h66, 5'd1), 1'b0, 1'b0);
    step(alu_op(32'h77, 5'd2), 1'b0, 1'b0);
    step(alu_op(32'h88, 5'd6), 1'b1, 1'b1);
    n_vec += 3;
    if (ex_dm_reg_wr !== 1'b0)    begin n_err++; $display("FAIL fs_ex_reg_wr: got %b want 0", ex_dm_reg_wr); end
    if (dm_wb_mux_out !== 32'h66) begin n_err++; $display("FAIL fs_wb_mux: got %h want 66", dm_wb_mux_out); end
    if (dm_wb_rd_addr !== 5'd1)   begin n_err++; $display("FAIL fs_wb_rd: got %0d want 1", dm_wb_rd_addr); end
    step(nop(), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_wb_reg_wr !== 1'b0) begin n_err++; $display("FAIL fs_bubble_wb: got %b want 0", dm_wb_reg_wr); end
  endtask

  task automatic test_wrap_align();
    step(st(32'h400, 32'hCAFE0001), 1'b0, 1'b0);
    step(ld(32'h0, 5'd6), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_wb_mux_out !== 32'hCAFE0001) begin n_err++; $display("FAIL wrap_alias: got %h want cafe0001", dm_wb_mux_out); end
    step(ld(32'h22, 5'd8), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    n_vec += 3;
    if (ALIGN) begin
      if (dm_err !== 1'b1)        begin n_err++; $display("FAIL align_err: got %b want 1", dm_err); end
      if (dm_wb_reg_wr !== 1'b0)  begin n_err++; $display("FAIL align_reg_wr: got %b want 0", dm_wb_reg_wr); end
      if (dm_wb_mux_out !== 32'h0) begin n_err++; $display("FAIL align_mux: got %h want 0", dm_wb_mux_out); end
    end else begin
      if (dm_err !== 1'b0)        begin n_err++; $display("FAIL align_err: got %b want 0", dm_err); end
      if (dm_wb_reg_wr !== 1'b1)  begin n_err++; $display("FAIL align_reg_wr: got %b want 1", dm_wb_reg_wr); end
      if (dm_wb_mux_out !== 32'h1) begin n_err++; $display("FAIL align_mux: got %h want 1", dm_wb_mux_out); end
    end
    step(nop(), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_err !== 1'b0) begin n_err++; $display("FAIL align_err_clear: got %b want 0", dm_err); end
  endtask

  task automatic test_reset_midstream();
    step(alu_op(32'h99, 5'd10), 1'b0, 1'b0);
    step(st(32'h40, 32'h12345678), 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    n_vec += 7;
    if (ex_dm_alu_out !== 32'h0) begin n_err++; $display("FAIL mrst_ex_alu: got %h want 0", ex_dm_alu_out); end
    if (ex_dm_rd_addr !== 5'h0)  begin n_err++; $display("FAIL mrst_ex_rd: got %h want 0", ex_dm_rd_addr); end
    if (ex_dm_reg_wr !== 1'b0)   begin n_err++; $display("FAIL mrst_ex_reg_wr: got %b want 0", ex_dm_reg_wr); end
    if (dm_wb_mux_out !== 32'h0) begin n_err++; $display("FAIL mrst_wb_mux: got %h want 0", dm_wb_mux_out); end
    if (dm_wb_rd_addr !== 5'h0)  begin n_err++; $display("FAIL mrst_wb_rd: got %h want 0", dm_wb_rd_addr); end
    if (dm_wb_reg_wr !== 1'b0)   begin n_err++; $display("FAIL mrst_wb_reg_wr: got %b want 0", dm_wb_reg_wr); end
    if (dm_err !== 1'b0)         begin n_err++; $display("FAIL mrst_err: got %b want 0", dm_err); end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(ld(32'h40, 5'd11), 1'b0, 1'b0);
    step(nop(), 1'b0, 1'b0);
    n_vec += 1;
    if (dm_wb_mux_out !== pre_val(16)) begin n_err++; $display("FAIL mrst_mem_kept: got %h want %h", dm_wb_mux_out, pre_val(16)); end
  endtask

  task automatic test_random();
    ins_t i;
    bit s, f;
    int unsigned kind;
    for (int n = 0; n < 400; n++) begin
      i.alu = $urandom();
      if ($urandom_range(0, 9) < 7) i.alu[1:0] = 2'b00;
      i.rt = $urandom();
      i.rd = 5'($urandom_range(0, 31));
      kind = $urandom_range(0, 3);
      i.reg_wr = (kind == 0) || (kind == 1);
      i.mem_rd = (kind == 1);
      i.m2r    = (kind == 1);
      i.mem_wr = (kind == 2);
      i.valid  = ($urandom_range(0, 99) < 85);
      s = ($urandom_range(0, 99) < 15);
      f = ($urandom_range(0, 99) < 10);
      step(i, s, f);
      n_vec += 3;
      if (ex_dm_reg_wr !== (m_ex.valid && m_ex.reg_wr)) begin
        n_err++; $display("FAIL rnd_ex_reg_wr[%0d]: got %b want %b", n, ex_dm_reg_wr, m_ex.valid && m_ex.reg_wr);
      end
      if (dm_wb_reg_wr !== (m_wb.valid && m_wb.reg_wr)) begin
        n_err++; $display("FAIL rnd_wb_reg_wr[%0d]: got %b want %b", n, dm_wb_reg_wr, m_wb.valid && m_wb.reg_wr);
      end
      if (dm_err !== m_wb.err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", n, dm_err, m_wb.err); end
      if (m_ex.valid) begin
        n_vec += 2;
        if (ex_dm_alu_out !== m_ex.alu) begin n_err++; $display("FAIL rnd_ex_alu[%0d]: got %h want %h", n, ex_dm_alu_out, m_ex.alu); end
        if (ex_dm_rd_addr !== m_ex.rd)  begin n_err++; $display("FAIL rnd_ex_rd[%0d]: got %0d want %0d", n, ex_dm_rd_addr, m_ex.rd); end
      end
      if (m_wb.valid) begin
        n_vec += 2;
        if (dm_wb_mux_out !== (m_wb.m2r ? m_wb.ld : m_wb.alu)) begin
          n_err++; $display("FAIL rnd_wb_mux[%0d]: got %h want %h", n, dm_wb_mux_out, m_wb.m2r ? m_wb.ld : m_wb.alu);
        end
        if (dm_wb_rd_addr !== m_wb.rd) begin n_err++; $display("FAIL rnd_wb_rd[%0d]: got %0d want %0d", n, dm_wb_rd_addr, m_wb.rd); end
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_store_load();
    test_forwarding();
    test_stall();
    test_flush();
    test_wrap_align();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
